// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite register bank.
// Contents: AXI response codes, channel FSM state types, and byte_merge(),
// which applies a byte-enable mask to a register word (up to 64 bits).
package axi4lite_pkg;

  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_REQ,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_RESP
  } rd_state_e;

  // Replace each byte of old_v whose strobe bit is set with the byte of new_v.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_v,
    input logic [MAX_DATA_W-1:0] new_v,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < int'(MAX_STRB_W); b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4lite_regbank_if.sv
// AXI4-Lite bus bundle between an interconnect master and the register bank.
// Ports: AW (awvalid/awready/awaddr/awprot), W (wvalid/wready/wdata/wstrb),
//        B (bvalid/bready/bresp), AR (arvalid/arready/araddr/arprot),
//        R (rvalid/rready/rdata/rresp). Modports: master, slave.
interface axi4lite_regbank_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/regbank_strb_reg.sv
// One byte-enabled register of the bank.
// Ports: clk, rst (sync, active-high), we (write enable), strb (byte enables),
//        d (write data), q (register contents, reset to RST_VAL).
module regbank_strb_reg
  import axi4lite_pkg::*;
#(
  parameter int unsigned        DATA_W  = 32,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   strb,
  input  logic [DATA_W-1:0]     d,
  output logic [DATA_W-1:0]     q
);

  // Byte-granular update through the shared merge helper.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (we) begin
      q <= DATA_W'(byte_merge(MAX_DATA_W'(q), MAX_DATA_W'(d), MAX_STRB_W'(strb)));
    end
  end

endmodule

// File: rtl/axi4lite_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS registers of DATA_W bits.
// Byte-strobe writes, read-only registers sourced from regs_i, per-register
// write pulses, SLVERR on writes to read-only regs, DECERR on unmapped addresses.
// Ports: aclk, areset (sync, active-high), bus (AXI4-Lite slave),
//        regs_o (register contents, RO slices 0), regs_i (status inputs for RO slices),
//        wr_pulse_o (one-cycle pulse per successful write).
module axi4lite_regbank
  import axi4lite_pkg::*;
#(
  parameter int unsigned                  NUM_REGS = 4,
  parameter int unsigned                  DATA_W   = 32,
  parameter int unsigned                  ADDR_W   = 4,
  parameter logic [NUM_REGS-1:0]          RO_MASK  = '0,
  parameter logic [NUM_REGS*DATA_W-1:0]   RST_VAL  = '0
) (
  input  logic                        aclk,
  input  logic                        areset,
  axi4lite_regbank_if.slave           bus,
  output logic [NUM_REGS*DATA_W-1:0]  regs_o,
  input  logic [NUM_REGS*DATA_W-1:0]  regs_i,
  output logic [NUM_REGS-1:0]         wr_pulse_o
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned ADDR_LSB = (DATA_W == 64) ? 3 : 2;
  localparam int unsigned IDX_W    = ADDR_W - ADDR_LSB;

  wr_state_e          wr_state, wr_state_n;
  rd_state_e          rd_state, rd_state_n;

  logic               aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0]   aw_idx_q, ar_idx_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [STRB_W-1:0]  wstrb_q;

  logic [NUM_REGS-1:0] aw_sel;
  logic                aw_ro;
  logic [1:0]          wr_resp_c;
  logic [NUM_REGS-1:0] reg_we;

  logic [DATA_W-1:0]   rd_data_c;
  logic                rd_hit;

  logic                unused_bits;

  assign aw_hs = bus.awvalid & bus.awready;
  assign w_hs  = bus.wvalid  & bus.wready;
  assign ar_hs = bus.arvalid & bus.arready;

  // Protection bits, byte-offset address bits and writable-slice status inputs carry no meaning here.
  assign unused_bits = ^{bus.awprot, bus.arprot, bus.awaddr[ADDR_LSB-1:0],
                         bus.araddr[ADDR_LSB-1:0], regs_i};

  // Payload capture at each handshake; readies keep these stable until consumed.
  always_ff @(posedge aclk) begin
    if (aw_hs) aw_idx_q <= bus.awaddr[ADDR_W-1:ADDR_LSB];
    if (w_hs) begin
      wdata_q <= bus.wdata;
      wstrb_q <= bus.wstrb;
    end
    if (ar_hs) ar_idx_q <= bus.araddr[ADDR_W-1:ADDR_LSB];
  end

  // Write index decode: one-hot select plus read-only flag of the selected register.
  always_comb begin
    aw_sel = '0;
    aw_ro  = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (aw_idx_q == IDX_W'(i)) begin
        aw_sel[i] = 1'b1;
        aw_ro     = RO_MASK[i];
      end
    end
  end

  always_comb begin
    wr_resp_c = RESP_OKAY;
    if (aw_sel == '0) wr_resp_c = RESP_DECERR;
    else if (aw_ro)   wr_resp_c = RESP_SLVERR;
  end

  // Commit only in the request cycle and only for a clean decode.
  assign reg_we = (wr_state == W_REQ && wr_resp_c == RESP_OKAY) ? aw_sel : '0;

  // Write channel next-state: AW and W collected in any order, then request, then response.
  always_comb begin
    wr_state_n = wr_state;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_state_n = W_REQ;
        else if (aw_hs)    wr_state_n = W_HAVE_AW;
        else if (w_hs)     wr_state_n = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)       wr_state_n = W_REQ;
      W_HAVE_W:  if (aw_hs)      wr_state_n = W_REQ;
      W_REQ:                     wr_state_n = W_RESP;
      W_RESP:    if (bus.bready) wr_state_n = W_IDLE;
      default:                   wr_state_n = W_IDLE;
    endcase
  end

  // Write channel state and registered outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state    <= W_IDLE;
      bus.awready <= 1'b1;
      bus.wready  <= 1'b1;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= RESP_OKAY;
      wr_pulse_o  <= '0;
    end else begin
      wr_state    <= wr_state_n;
      bus.awready <= (wr_state_n == W_IDLE) || (wr_state_n == W_HAVE_W);
      bus.wready  <= (wr_state_n == W_IDLE) || (wr_state_n == W_HAVE_AW);
      bus.bvalid  <= (wr_state_n == W_RESP);
      if (wr_state == W_REQ) bus.bresp <= wr_resp_c;
      wr_pulse_o  <= reg_we;
    end
  end

  // Read mux: RO registers come straight from the status inputs.
  always_comb begin
    rd_data_c = '0;
    rd_hit    = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ar_idx_q == IDX_W'(i)) begin
        rd_hit    = 1'b1;
        rd_data_c = RO_MASK[i] ? regs_i[i*DATA_W +: DATA_W] : regs_o[i*DATA_W +: DATA_W];
      end
    end
  end

  // Read channel next-state: address, one sampling cycle, then hold response.
  always_comb begin
    rd_state_n = rd_state;
    case (rd_state)
      R_IDLE: if (ar_hs)      rd_state_n = R_REQ;
      R_REQ:                  rd_state_n = R_RESP;
      R_RESP: if (bus.rready) rd_state_n = R_IDLE;
      default:                rd_state_n = R_IDLE;
    endcase
  end

  // Read channel state and registered outputs; data sampled in the request cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state    <= R_IDLE;
      bus.arready <= 1'b1;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rresp   <= RESP_OKAY;
    end else begin
      rd_state    <= rd_state_n;
      bus.arready <= (rd_state_n == R_IDLE);
      bus.rvalid  <= (rd_state_n == R_RESP);
      if (rd_state == R_REQ) begin
        bus.rdata <= rd_data_c;
        bus.rresp <= rd_hit ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  // Storage only for writable indices; RO slices of regs_o are tied low.
  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign regs_o[i*DATA_W +: DATA_W] = '0;
    end else begin : g_rw
      regbank_strb_reg #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL[i*DATA_W +: DATA_W])
      ) u_reg (
        .clk  (aclk),
        .rst  (areset),
        .we   (reg_we[i]),
        .strb (wstrb_q),
        .d    (wdata_q),
        .q    (regs_o[i*DATA_W +: DATA_W])
      );
    end
  end

endmodule

// File: tb/tb_axi4lite_regbank.sv
// Self-checking bench for axi4lite_regbank (3 x 32-bit regs, reg 2 read-only).
// Directed scenarios followed by randomized reads/writes against a simple array model.
module tb_axi4lite_regbank;

  localparam int unsigned NUM_REGS = 3;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 4;
  localparam logic [2:0]  RO_MASK  = 3'b100;
  localparam logic [95:0] RST_VAL  = {32'h0BAD_F00D, 32'h1234_5678, 32'hAAAA_AAAA};

  logic        clk = 1'b0;
  logic        areset;
  logic [95:0] regs_o;
  logic [95:0] regs_i;
  logic [2:0]  wr_pulse_o;

  axi4lite_regbank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi4lite_regbank #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .RO_MASK  (RO_MASK),
    .RST_VAL  (RST_VAL)
  ) dut (
    .aclk       (clk),
    .areset     (areset),
    .bus        (bus),
    .regs_o     (regs_o),
    .regs_i     (regs_i),
    .wr_pulse_o (wr_pulse_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mdl [NUM_REGS];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void mdl_reset();
    for (int i = 0; i < int'(NUM_REGS); i++) mdl[i] = RST_VAL[i*32 +: 32];
  endfunction

  function automatic logic [95:0] mdl_regs_o();
    logic [95:0] v;
    for (int i = 0; i < int'(NUM_REGS); i++) v[i*32 +: 32] = RO_MASK[i] ? 32'h0 : mdl[i];
    return v;
  endfunction

  function automatic logic [1:0] exp_wresp(input logic [3:0] addr);
    int idx;
    idx = int'(addr) / 4;
    if (idx >= int'(NUM_REGS)) return 2'b11;
    if (RO_MASK[idx]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void mdl_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr) / 4;
    if (exp_wresp(addr) != 2'b00) return;
    for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // order: 0 = AW and W together, 1 = AW first, 2 = W first. bdelay = cycles bready held low.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int order, input int bdelay);
    logic [1:0] er;
    logic [2:0] ep;
    logic       aw_p, w_p, afire, wfire;
    int         guard;
    er    = exp_wresp(addr);
    ep    = (er == 2'b00) ? 3'(1 << (int'(addr) / 4)) : 3'b000;
    aw_p  = 1'b1;
    w_p   = 1'b1;
    guard = 0;
    bus.awaddr = addr;
    bus.awprot = 3'($urandom);
    bus.wdata  = data;
    bus.wstrb  = strb;
    while ((aw_p || w_p) && guard < 50) begin
      bus.awvalid = aw_p && (order != 2 || !w_p);
      bus.wvalid  = w_p  && (order != 1 || !aw_p);
      afire = bus.awvalid && bus.awready;
      wfire = bus.wvalid  && bus.wready;
      tick();
      if (afire) aw_p = 1'b0;
      if (wfire) w_p  = 1'b0;
      guard++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (guard >= 50) check("aw_w_timeout", 1'b0, 1'b1);
    guard = 0;
    while (!bus.bvalid && guard < 10) begin
      check("pulse_before_b", wr_pulse_o, 3'b000);
      tick();
      guard++;
    end
    mdl_write(addr, data, strb);
    check("bvalid_seen", bus.bvalid, 1'b1);
    check("bresp", bus.bresp, er);
    check("wr_pulse", wr_pulse_o, ep);
    check("regs_o_commit", regs_o, mdl_regs_o());
    for (int d = 0; d < bdelay; d++) begin
      tick();
      check("b_hold", {bus.bvalid, bus.bresp, bus.awready, bus.wready, wr_pulse_o}, {1'b1, er, 1'b0, 1'b0, 3'b000});
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("b_done", {bus.bvalid, bus.awready, bus.wready, wr_pulse_o}, {1'b0, 1'b1, 1'b1, 3'b000});
  endtask

  // rdelay = cycles rready held low; regs_i is disturbed meanwhile to prove rdata is held.
  task automatic axi_read(input logic [3:0] addr, input int rdelay);
    logic [31:0] ed;
    logic [1:0]  er;
    logic [95:0] saved;
    int          idx, guard;
    idx = int'(addr) / 4;
    if (idx >= int'(NUM_REGS)) begin
      ed = 32'h0;
      er = 2'b11;
    end else begin
      ed = RO_MASK[idx] ? regs_i[idx*32 +: 32] : mdl[idx];
      er = 2'b00;
    end
    bus.araddr  = addr;
    bus.arprot  = 3'($urandom);
    bus.arvalid = 1'b1;
    guard = 0;
    while (!bus.arready && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) check("ar_timeout", 1'b0, 1'b1);
    tick();
    bus.arvalid = 1'b0;
    check("rvalid_t1", bus.rvalid, 1'b0);
    tick();
    check("rvalid_t2", bus.rvalid, 1'b1);
    check("rdata", bus.rdata, ed);
    check("rresp", bus.rresp, er);
    saved = regs_i;
    for (int d = 0; d < rdelay; d++) begin
      regs_i = ~regs_i;
      tick();
      check("r_hold", {bus.rvalid, bus.arready, bus.rresp, bus.rdata}, {1'b1, 1'b0, er, ed});
    end
    regs_i = saved;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check("r_done", {bus.rvalid, bus.arready}, 2'b01);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  a1, a2;
    logic [31:0] d1;
    areset      = 1'b1;
    regs_i      = '0;
    bus.awvalid = 1'b0;
    bus.awaddr  = '0;
    bus.awprot  = '0;
    bus.wvalid  = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0;
    bus.araddr  = '0;
    bus.arprot  = '0;
    bus.rready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
    mdl_reset();

    check("rst_ready_valid", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 5'b11100);
    check("rst_resp_data", {bus.bresp, bus.rresp, bus.rdata}, 36'h0);
    check("rst_pulse", wr_pulse_o, 3'b000);
    check("rst_regs", regs_o, {32'h0, RST_VAL[63:0]});

    // Reset values read back
    axi_read(4'h0, 0);
    axi_read(4'h4, 2);

    // W before AW, full word
    axi_write(4'h4, 32'hDEADBEEF, 4'hF, 2, 0);
    axi_read(4'h4, 0);
    check("t2_value", regs_o[63:32], 32'hDEADBEEF);

    // Partial strobe over a known pattern
    axi_write(4'h0, 32'hAAAAAAAA, 4'hF, 0, 0);
    axi_write(4'h0, 32'h11223344, 4'h5, 1, 1);
    axi_read(4'h0, 0);
    check("t3_value", regs_o[31:0], 32'hAA22AA44);

    // Zero strobe: OKAY, pulse, no change
    axi_write(4'h1, 32'h55555555, 4'h0, 0, 0);
    check("strb0_value", regs_o[31:0], 32'hAA22AA44);

    // Read-only register
    regs_i = {32'hCAFE0001, 64'h0};
    axi_read(4'h8, 1);
    axi_write(4'h8, 32'h99999999, 4'hF, 0, 0);
    axi_read(4'hA, 0);
    check("t4_regs_o", regs_o[95:64], 32'h0);

    // Unmapped address, long B backpressure
    axi_read(4'hC, 0);
    axi_write(4'hC, 32'h12121212, 4'hF, 1, 5);

    // Read concurrent with write to the same register sees the old value
    fork
      axi_write(4'h4, 32'h0F0F0F0F, 4'hF, 0, 0);
      axi_read(4'h4, 0);
    join
    check("collide_after", regs_o[63:32], 32'h0F0F0F0F);

    // Randomized traffic
    for (int k = 0; k < 80; k++) begin
      regs_i = {$urandom, $urandom, $urandom};
      a1 = 4'($urandom_range(0, 15));
      a2 = 4'($urandom_range(0, 15));
      d1 = $urandom;
      case ($urandom_range(0, 2))
        0: axi_write(a1, d1, 4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        1: axi_read(a1, int'($urandom_range(0, 3)));
        default: begin
          fork
            axi_write(a1, d1, 4'($urandom), 0, int'($urandom_range(0, 2)));
            axi_read(a2, int'($urandom_range(0, 2)));
          join
        end
      endcase
    end

    // Reset with AW accepted and W still pending
    bus.awaddr  = 4'h4;
    bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    check("t6_aw_taken", {bus.awready, bus.wready}, 2'b01);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    mdl_reset();
    check("t6_ready_valid", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 5'b11100);
    check("t6_pulse", wr_pulse_o, 3'b000);
    check("t6_regs", regs_o, {32'h0, RST_VAL[63:0]});
    repeat (4) tick();
    check("t6_no_resp", {bus.bvalid, wr_pulse_o}, 4'b0000);
    axi_write(4'h0, 32'h01020304, 4'hF, 0, 0);
    axi_read(4'h4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
